// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for the multicycle controller.
//   state_t     : controller FSM states
//   OP_*        : instruction opcode field values
//   ALU_*       : alucontrol function codes
//   SRCB_*, PCSRC_*, REGDST_*, MTR_* : datapath mux select encodings
//   ctrl_out_t  : bundle of every controller output, produced by ctrl_outdec
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_REXEC  = 4'd2,
    S_ALUWB  = 4'd3,
    S_IEXEC  = 4'd4,
    S_IWB    = 4'd5,
    S_MEMADR = 4'd6,
    S_MEMRD  = 4'd7,
    S_MEMWB  = 4'd8,
    S_MEMWR  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JR     = 4'd12,
    S_JAL    = 4'd13,
    S_FAULT  = 4'd14
  } state_t;

  // Opcodes
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_R4   = 4'b0100;
  localparam logic [3:0] OP_JR   = 4'b0101;
  localparam logic [3:0] OP_R6   = 4'b0110;
  localparam logic [3:0] OP_R7   = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_ADDI = 4'b1001;
  localparam logic [3:0] OP_SUBI = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_LW   = 4'b1100;
  localparam logic [3:0] OP_SW   = 4'b1101;
  localparam logic [3:0] OP_J    = 4'b1110;
  localparam logic [3:0] OP_JAL  = 4'b1111;

  // ALU function codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_TWO = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_OFF = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  // Register destination select
  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;
  localparam logic [1:0] REGDST_LINK = 2'b10;

  // Register write-data select
  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [2:0] alucontrol;
    logic       instr_done;
    logic       fault;
  } ctrl_out_t;

  // States that wait on mem_ready and are guarded by the timeout counter.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

  // ALU function for register-register instructions.
  function automatic logic [2:0] rexec_alu(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// ctrl_outdec -- combinational output decoder for the multicycle controller.
// Ports:
//   i_state     : current FSM state
//   i_opcode    : instruction opcode (selects ALU function in execute states)
//   i_zero      : ALU zero flag (branch decision)
//   i_mem_ready : memory access completes this cycle
//   o_ctrl      : all controller outputs; anything a state does not drive is 0
module ctrl_outdec
  import ctrl_pkg::*;
(
  input  state_t      i_state,
  input  logic [3:0]  i_opcode,
  input  logic        i_zero,
  input  logic        i_mem_ready,
  output ctrl_out_t   o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.alusrcb    = SRCB_TWO;
        o_ctrl.alucontrol = ALU_ADD;
        o_ctrl.pcsrc      = PCSRC_ALU;
        // Instruction and PC+2 are only captured once the fetch completes.
        o_ctrl.irwrite    = i_mem_ready;
        o_ctrl.pcwrite    = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alusrcb    = SRCB_OFF;
        o_ctrl.alucontrol = ALU_ADD;
      end
      S_REXEC: begin
        o_ctrl.alusrca    = 1'b1;
        o_ctrl.alusrcb    = SRCB_REG;
        o_ctrl.alucontrol = rexec_alu(i_opcode);
      end
      S_ALUWB: begin
        o_ctrl.regdst     = REGDST_RD;
        o_ctrl.memtoreg   = MTR_ALU;
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_IEXEC: begin
        o_ctrl.alusrca    = 1'b1;
        o_ctrl.alusrcb    = SRCB_IMM;
        o_ctrl.alucontrol = (i_opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
      end
      S_IWB: begin
        o_ctrl.regdst     = REGDST_RT;
        o_ctrl.memtoreg   = MTR_ALU;
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMADR: begin
        o_ctrl.alusrca    = 1'b1;
        o_ctrl.alusrcb    = SRCB_IMM;
        o_ctrl.alucontrol = ALU_ADD;
      end
      S_MEMRD: begin
        o_ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.regdst     = REGDST_RT;
        o_ctrl.memtoreg   = MTR_MEM;
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.iord       = 1'b1;
        o_ctrl.memwrite   = 1'b1;
        // The store retires in the cycle memory accepts it.
        o_ctrl.instr_done = i_mem_ready;
      end
      S_BRANCH: begin
        o_ctrl.alusrca    = 1'b1;
        o_ctrl.alusrcb    = SRCB_REG;
        o_ctrl.alucontrol = ALU_SUB;
        o_ctrl.pcsrc      = PCSRC_ALUOUT;
        o_ctrl.pcwrite    = i_zero;
        o_ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pcsrc      = PCSRC_JUMP;
        o_ctrl.pcwrite    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_JR: begin
        o_ctrl.pcsrc      = PCSRC_REG;
        o_ctrl.pcwrite    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        o_ctrl.pcsrc      = PCSRC_JUMP;
        o_ctrl.pcwrite    = 1'b1;
        o_ctrl.regdst     = REGDST_LINK;
        o_ctrl.memtoreg   = MTR_PC;
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_FAULT: begin
        o_ctrl.fault = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multicycle processor control FSM with memory-wait timeout.
// Parameter:
//   WAIT_LIMIT : cycles a state may wait on mem_ready before entering FAULT
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   opcode, zero        : instruction opcode field, ALU zero flag
//   mem_ready           : memory completes the current access this cycle
//   pcwrite, irwrite, regwrite, memwrite, iord, alusrca : datapath strobes/selects
//   alusrcb, pcsrc, regdst, memtoreg : 2-bit mux selects
//   alucontrol          : ALU function
//   instr_done          : one-cycle pulse when an instruction retires
//   fault               : sticky memory-timeout flag, cleared only by reset
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic [2:0] alucontrol,
  output logic       instr_done,
  output logic       fault
);

  localparam int CNT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WAIT_LIMIT);
  localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(WAIT_LIMIT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_waiting;
  logic             w_timeout;
  ctrl_out_t        w_ctrl;

  // Timeout fires in the cycle the counter would reach WAIT_LIMIT;
  // mem_ready in that same cycle takes priority.
  assign w_waiting = is_wait_state(r_state);
  assign w_timeout = w_waiting && !mem_ready && (r_cnt == CNT_FINAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_R4,
          OP_R6, OP_R7, OP_SLT:  w_next = S_REXEC;
          OP_ADDI, OP_SUBI:      w_next = S_IEXEC;
          OP_BEQ:                w_next = S_BRANCH;
          OP_LW, OP_SW:          w_next = S_MEMADR;
          OP_JR:                 w_next = S_JR;
          OP_J:                  w_next = S_JUMP;
          OP_JAL:                w_next = S_JAL;
          default:               w_next = S_FETCH;
        endcase
      end
      S_REXEC:  w_next = S_ALUWB;
      S_IEXEC:  w_next = S_IWB;
      S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_MEMWR: begin
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_ALUWB, S_IWB, S_MEMWB,
      S_BRANCH, S_JUMP, S_JR, S_JAL: w_next = S_FETCH;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FETCH;
    endcase
  end

  // Wait counter: zero whenever a wait state is entered (or left),
  // counts cycles spent in a wait state without mem_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_waiting && (w_next == r_state)) begin
      if (!mem_ready && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_zero      (zero),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // State sits at FETCH during reset, where pcwrite/irwrite follow
  // mem_ready; the write strobes are masked so nothing commits under reset.
  assign pcwrite    = w_ctrl.pcwrite    & ~reset;
  assign irwrite    = w_ctrl.irwrite    & ~reset;
  assign regwrite   = w_ctrl.regwrite   & ~reset;
  assign memwrite   = w_ctrl.memwrite   & ~reset;
  assign instr_done = w_ctrl.instr_done & ~reset;
  assign iord       = w_ctrl.iord;
  assign alusrca    = w_ctrl.alusrca;
  assign alusrcb    = w_ctrl.alusrcb;
  assign pcsrc      = w_ctrl.pcsrc;
  assign regdst     = w_ctrl.regdst;
  assign memtoreg   = w_ctrl.memtoreg;
  assign alucontrol = w_ctrl.alucontrol;
  assign fault      = w_ctrl.fault;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl -- directed-vector bench for multicycle_ctrl.
// All outputs are packed into one 19-bit word:
//   {pcwrite,irwrite,regwrite,memwrite,iord,alusrca,alusrcb,pcsrc,regdst,memtoreg,alucontrol,instr_done,fault}
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite, irwrite, regwrite, memwrite, iord, alusrca;
  logic [1:0] alusrcb, pcsrc, regdst, memtoreg;
  logic [2:0] alucontrol;
  logic       instr_done, fault;

  int n_checks = 0;
  int n_errors = 0;

  logic [18:0] w_outs;
  assign w_outs = {pcwrite, irwrite, regwrite, memwrite, iord, alusrca,
                   alusrcb, pcsrc, regdst, memtoreg, alucontrol, instr_done, fault};

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_LIMIT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcwrite    (pcwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .iord       (iord),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alucontrol (alucontrol),
    .instr_done (instr_done),
    .fault      (fault)
  );

  function automatic logic [18:0] mk(
    input logic pcw, irw, rw, mw, io, asa,
    input logic [1:0] asb, pcs, rd, mtr,
    input logic [2:0] alu,
    input logic done, flt);
    return {pcw, irw, rw, mw, io, asa, asb, pcs, rd, mtr, alu, done, flt};
  endfunction

  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs already set; outputs sampled at the falling edge.
  task automatic cyc(input string tag, input logic [18:0] exp);
    @(negedge clk);
    check(tag, w_outs, exp);
    @(posedge clk);
    #1;
  endtask

  logic [18:0] P_RST, P_FETCH_RDY, P_FETCH_WAIT, P_DECODE, P_ALUWB, P_FAULT;

  task automatic run_r(input logic [3:0] op, input logic [2:0] alu, input string tag);
    opcode = op; mem_ready = 1'b1;
    cyc({tag, "_fetch"},  P_FETCH_RDY);
    cyc({tag, "_decode"}, P_DECODE);
    cyc({tag, "_rexec"},  mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, alu, 0,0));
    cyc({tag, "_aluwb"},  P_ALUWB);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    cyc(tag, P_RST);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    P_RST        = mk(0,0,0,0,0,0, 2'b01,2'b00,2'b00,2'b00, 3'b010, 0,0);
    P_FETCH_RDY  = mk(1,1,0,0,0,0, 2'b01,2'b00,2'b00,2'b00, 3'b010, 0,0);
    P_FETCH_WAIT = mk(0,0,0,0,0,0, 2'b01,2'b00,2'b00,2'b00, 3'b010, 0,0);
    P_DECODE     = mk(0,0,0,0,0,0, 2'b11,2'b00,2'b00,2'b00, 3'b010, 0,0);
    P_ALUWB      = mk(0,0,1,0,0,0, 2'b00,2'b00,2'b01,2'b00, 3'b000, 1,0);
    P_FAULT      = mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,1);

    reset = 1'b1; opcode = 4'b0000; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    cyc("reset_held", P_RST);
    reset = 1'b0;

    // Register-register instructions
    run_r(4'b0000, 3'b010, "add");
    run_r(4'b0001, 3'b110, "sub");
    run_r(4'b0010, 3'b000, "and");
    run_r(4'b0011, 3'b001, "or");
    run_r(4'b1000, 3'b111, "slt");
    run_r(4'b0100, 3'b010, "op4");

    // Immediate forms
    opcode = 4'b1001;
    cyc("addi_fetch",  P_FETCH_RDY);
    cyc("addi_decode", P_DECODE);
    cyc("addi_iexec",  mk(0,0,0,0,0,1, 2'b10,2'b00,2'b00,2'b00, 3'b010, 0,0));
    cyc("addi_iwb",    mk(0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,0));
    opcode = 4'b1010;
    cyc("subi_fetch",  P_FETCH_RDY);
    cyc("subi_decode", P_DECODE);
    cyc("subi_iexec",  mk(0,0,0,0,0,1, 2'b10,2'b00,2'b00,2'b00, 3'b110, 0,0));
    cyc("subi_iwb",    mk(0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,0));

    // lw with three not-ready cycles in MEMRD
    opcode = 4'b1100;
    cyc("lw_fetch",  P_FETCH_RDY);
    cyc("lw_decode", P_DECODE);
    cyc("lw_memadr", mk(0,0,0,0,0,1, 2'b10,2'b00,2'b00,2'b00, 3'b010, 0,0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("lw_memrd_wait", mk(0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0));
    mem_ready = 1'b1;
    cyc("lw_memrd_rdy", mk(0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0));
    cyc("lw_memwb",     mk(0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 1,0));

    // sw with one not-ready cycle
    opcode = 4'b1101;
    cyc("sw_fetch",  P_FETCH_RDY);
    cyc("sw_decode", P_DECODE);
    cyc("sw_memadr", mk(0,0,0,0,0,1, 2'b10,2'b00,2'b00,2'b00, 3'b010, 0,0));
    mem_ready = 1'b0;
    cyc("sw_memwr_wait", mk(0,0,0,1,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0));
    mem_ready = 1'b1;
    cyc("sw_memwr_rdy",  mk(0,0,0,1,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,0));

    // beq taken then not taken
    opcode = 4'b1011; zero = 1'b1;
    cyc("beq1_fetch",  P_FETCH_RDY);
    cyc("beq1_decode", P_DECODE);
    cyc("beq1_branch", mk(1,0,0,0,0,1, 2'b00,2'b01,2'b00,2'b00, 3'b110, 1,0));
    zero = 1'b0;
    cyc("beq0_fetch",  P_FETCH_RDY);
    cyc("beq0_decode", P_DECODE);
    cyc("beq0_branch", mk(0,0,0,0,0,1, 2'b00,2'b01,2'b00,2'b00, 3'b110, 1,0));

    // Jumps
    opcode = 4'b1111;
    cyc("jal_fetch",  P_FETCH_RDY);
    cyc("jal_decode", P_DECODE);
    cyc("jal_exec",   mk(1,0,1,0,0,0, 2'b00,2'b10,2'b10,2'b10, 3'b000, 1,0));
    opcode = 4'b1110;
    cyc("j_fetch",  P_FETCH_RDY);
    cyc("j_decode", P_DECODE);
    cyc("j_exec",   mk(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00, 3'b000, 1,0));
    opcode = 4'b0101;
    cyc("jr_fetch",  P_FETCH_RDY);
    cyc("jr_decode", P_DECODE);
    cyc("jr_exec",   mk(1,0,0,0,0,0, 2'b00,2'b11,2'b00,2'b00, 3'b000, 1,0));

    // Fetch timeout: 15 waiting cycles, then FAULT which is sticky
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc("to_fetch_wait", P_FETCH_WAIT);
    cyc("to_fault", P_FAULT);
    mem_ready = 1'b1;
    cyc("to_fault_sticky1", P_FAULT);
    cyc("to_fault_sticky2", P_FAULT);
    do_reset("to_reset");
    mem_ready = 1'b1;
    cyc("post_fault_fetch", P_FETCH_RDY);
    cyc("post_fault_decode", P_DECODE);
    cyc("post_fault_jr", mk(1,0,0,0,0,0, 2'b00,2'b11,2'b00,2'b00, 3'b000, 1,0));

    // mem_ready arriving in the 15th waiting cycle wins over the timeout
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) cyc("edge_fetch_wait", P_FETCH_WAIT);
    mem_ready = 1'b1;
    cyc("edge_fetch_rdy", P_FETCH_RDY);
    cyc("edge_decode",    P_DECODE);
    cyc("edge_jr",        mk(1,0,0,0,0,0, 2'b00,2'b11,2'b00,2'b00, 3'b000, 1,0));

    // Reset during MEMWR while memwrite is asserted
    opcode = 4'b1101;
    cyc("rst_sw_fetch",  P_FETCH_RDY);
    cyc("rst_sw_decode", P_DECODE);
    cyc("rst_sw_memadr", mk(0,0,0,0,0,1, 2'b10,2'b00,2'b00,2'b00, 3'b010, 0,0));
    mem_ready = 1'b0;
    cyc("rst_sw_memwr", mk(0,0,0,1,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0));
    check("rst_sw_memwr_still", w_outs, mk(0,0,0,1,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0));
    reset = 1'b1;
    #1;
    check("rst_async_drop", w_outs, P_RST);
    mem_ready = 1'b1;
    @(negedge clk);
    check("rst_gated_strobes", w_outs, P_RST);
    @(posedge clk); #1;
    reset = 1'b0;
    opcode = 4'b1110;
    cyc("rst_post_fetch",  P_FETCH_RDY);
    cyc("rst_post_decode", P_DECODE);
    cyc("rst_post_jump",   mk(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b00, 3'b000, 1,0));
    cyc("rst_post_fetch2", P_FETCH_RDY);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
